// File: rtl/therm_pkg.sv
// Shared types and constants for the thermistor scanner: FSM states,
// breakpoint table type with its default contents, and the fault code.
package therm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GAP,
    ST_REQ,
    ST_CALC1,
    ST_CALC2,
    ST_EMIT
  } state_e;

  // Entry i is the temperature (1/16 degC) at code = i * 2^(ADC_W-4).
  typedef logic [16:0][15:0] lut_t;

  // Listed from index 16 down to index 0 (NTC divider: temperature falls as code rises).
  localparam lut_t TEMP_LUT_DEF = {
    -16'sd400, -16'sd320, -16'sd240, -16'sd160, -16'sd80,  16'sd0,
     16'sd80,   16'sd160,  16'sd240,  16'sd320,  16'sd400, 16'sd480,
     16'sd560,  16'sd640,  16'sd720,  16'sd800,  16'sd1568
  };

  localparam logic [15:0] FAULT_VAL = 16'h8000;

  function automatic logic signed [15:0] lut_at(input lut_t lut, input logic [4:0] idx);
    return $signed(lut[idx]);
  endfunction

endpackage

// File: rtl/therm_interp.sv
// Two-stage piecewise-linear interpolator: stage 1 registers the segment base
// and slope*fraction product, stage 2 registers the final temperature.
module therm_interp
  import therm_pkg::*;
#(
  parameter int   ADC_W    = 12,
  parameter lut_t TEMP_LUT = TEMP_LUT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_i,
  input  logic [ADC_W-1:0]   code_i,
  output logic               valid_o,
  output logic signed [15:0] temp_o
);

  localparam int FW = ADC_W - 4;
  localparam int PW = 17 + FW + 1;

  logic [4:0]           seg;
  logic [FW-1:0]        frac;
  logic signed [15:0]   base_d, base_q, next_pt;
  logic signed [16:0]   diff;
  logic signed [PW-1:0] prod_d, prod_q;
  logic signed [15:0]   temp_d, temp_q;
  logic                 v1_q, v2_q;

  always_comb begin
    seg     = {1'b0, code_i[ADC_W-1 -: 4]};
    frac    = code_i[FW-1:0];
    base_d  = lut_at(TEMP_LUT, seg);
    next_pt = lut_at(TEMP_LUT, seg + 5'd1);
    diff    = {next_pt[15], next_pt} - {base_d[15], base_d};
    prod_d  = PW'(diff) * PW'($signed({1'b0, frac}));
    // Arithmetic shift floors toward minus infinity on falling segments.
    temp_d  = base_q + 16'(prod_q >>> FW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      prod_q <= '0;
      temp_q <= '0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
    end else begin
      base_q <= base_d;
      prod_q <= prod_d;
      temp_q <= temp_d;
      v1_q   <= valid_i;
      v2_q   <= v1_q;
    end
  end

  assign valid_o = v2_q;
  assign temp_o  = temp_q;

endmodule

// File: rtl/thermistor_scan_conv.sv
// Round-robin thermistor scanner: requests one ADC sample per channel, converts
// it to 1/16 degC through the interpolator and keeps per-channel alarm/fault flags.
module thermistor_scan_conv
  import therm_pkg::*;
#(
  parameter int   N_CH     = 4,
  parameter int   ADC_W    = 12,
  parameter int   SCAN_GAP = 16,
  parameter int   TIMEOUT  = 255,
  parameter lut_t TEMP_LUT = TEMP_LUT_DEF,
  parameter logic signed [15:0] HI_THR = 16'sd1280,
  parameter logic signed [15:0] HYST   = 16'sd80,
  localparam int  CW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               scan_en,
  output logic               adc_req,
  output logic [CW-1:0]      adc_ch,
  input  logic               adc_ack,
  input  logic [ADC_W-1:0]   adc_data,
  output logic               temp_valid,
  output logic [CW-1:0]      temp_ch,
  output logic signed [15:0] temp_out,
  output logic [N_CH-1:0]    alarm,
  output logic [N_CH-1:0]    fault
);

  state_e             state_q, state_d;
  logic [CW-1:0]      ch_q, ch_d, last_ch_q;
  logic [15:0]        wait_q, wait_d, gap_q, gap_d;
  logic [ADC_W-1:0]   code_q, code_d;
  logic               flt_q, flt_d;
  logic signed [15:0] last_temp_q, emit_val, it, lo_thr;
  logic [N_CH-1:0]    alarm_q, alarm_d, fault_q, fault_d;
  logic               emit, iv, bad_result;

  therm_interp #(
    .ADC_W    (ADC_W),
    .TEMP_LUT (TEMP_LUT)
  ) u_interp (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (state_q == ST_CALC1),
    .code_i  (code_q),
    .valid_o (iv),
    .temp_o  (it)
  );

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    wait_d  = wait_q;
    gap_d   = gap_q;
    code_d  = code_q;
    flt_d   = flt_q;
    case (state_q)
      ST_IDLE: begin
        wait_d = '0;
        if (scan_en) state_d = ST_REQ;
      end
      ST_GAP: begin
        if (!scan_en) begin
          state_d = ST_IDLE;
        end else if (gap_q == 16'(SCAN_GAP - 1)) begin
          state_d = ST_REQ;
          wait_d  = '0;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      ST_REQ: begin
        // An ack arriving on the timeout cycle still counts as a sample.
        if (adc_ack) begin
          code_d  = adc_data;
          flt_d   = (adc_data == '0) || (&adc_data);
          state_d = ST_CALC1;
        end else if (wait_q == 16'(TIMEOUT)) begin
          flt_d   = 1'b1;
          state_d = ST_EMIT;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      ST_CALC1: state_d = ST_CALC2;
      ST_CALC2: state_d = ST_EMIT;
      ST_EMIT: begin
        ch_d = (ch_q == CW'(N_CH - 1)) ? '0 : ch_q + CW'(1);
        if (!scan_en) begin
          state_d = ST_IDLE;
        end else if (SCAN_GAP == 0) begin
          state_d = ST_REQ;
          wait_d  = '0;
        end else begin
          state_d = ST_GAP;
          gap_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    emit       = (state_q == ST_EMIT);
    bad_result = flt_q || !iv;
    lo_thr     = HI_THR - HYST;
    emit_val   = bad_result ? $signed(FAULT_VAL) : it;
    alarm_d    = alarm_q;
    fault_d    = fault_q;
    if (emit) begin
      if (bad_result) begin
        fault_d[ch_q] = 1'b1;
      end else begin
        fault_d[ch_q] = 1'b0;
        if (it >= HI_THR)     alarm_d[ch_q] = 1'b1;
        else if (it < lo_thr) alarm_d[ch_q] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      wait_q      <= '0;
      gap_q       <= '0;
      code_q      <= '0;
      flt_q       <= 1'b0;
      last_temp_q <= '0;
      last_ch_q   <= '0;
      alarm_q     <= '0;
      fault_q     <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      wait_q  <= wait_d;
      gap_q   <= gap_d;
      code_q  <= code_d;
      flt_q   <= flt_d;
      alarm_q <= alarm_d;
      fault_q <= fault_d;
      if (emit) begin
        last_temp_q <= emit_val;
        last_ch_q   <= ch_q;
      end
    end
  end

  // The result is shown live during EMIT and held from the registers afterwards.
  assign adc_req    = (state_q == ST_REQ);
  assign adc_ch     = ch_q;
  assign temp_valid = emit;
  assign temp_out   = emit ? emit_val : last_temp_q;
  assign temp_ch    = emit ? ch_q : last_ch_q;
  assign alarm      = alarm_q;
  assign fault      = fault_q;

endmodule
